// File: rtl/ram_line_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ram_line_responder
//  Purpose  : Line-oriented backing RAM for a cache controller. Accepts one
//             128-bit line request (refill read or write-back). It waits
//             LATENCY cycles, moves the line as four 32-bit beats, and then
//             pulses a one-cycle response.
//  Ports    : clk                   - single clock, rising edge
//             rst                   - asynchronous, active-low reset
//             enable_cache_to_ram   - request valid (held until response)
//             write_cache_to_ram    - 1 = write-back, 0 = refill read
//             addr_cache_to_ram     - byte address, bits [3:0] ignored
//             data_cache_to_ram     - write line, word k at [32k+31:32k]
//             response_ram_to_cache - one-cycle completion pulse
//             data_ram_to_cache     - last read line, same packing
//             ram_busy              - high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module ram_line_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_cache_to_ram,
  input  logic         write_cache_to_ram,
  input  logic [31:0]  addr_cache_to_ram,
  input  logic [127:0] data_cache_to_ram,
  output logic         response_ram_to_cache,
  output logic [127:0] data_ram_to_cache,
  output logic         ram_busy
);

  localparam int         c_addr_w   = $clog2(MEM_WORDS);
  // Last value of the wait counter before leaving WAIT. WAIT is never
  // entered when LATENCY is 0, so the value in that case does not matter.
  localparam logic [3:0] c_lat_last = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_lat_cnt;
  logic [3:0]            w_lat_cnt_next;
  logic [1:0]            r_beat;
  logic [1:0]            w_beat_next;
  logic                  w_accept;
  logic                  w_mem_we;
  logic                  w_rd_beat;

  logic                  r_write;
  logic [c_addr_w-1:0]   r_base;
  logic [127:0]          r_wdata;
  logic [127:0]          r_rdata;

  logic [c_addr_w-1:0]   w_base;
  logic [c_addr_w-1:0]   w_word_idx;
  logic [31:0]           w_mem_rdata;
  logic [31:0]           w_mem_wdata;
  logic                  w_unused_addr;

  logic [31:0]           r_mem [MEM_WORDS];

  // The first word of the line. The line index is truncated to the array
  // depth, so out-of-range addresses alias onto lower lines.
  if (c_addr_w > 2) begin : g_line_bits
    assign w_base = {addr_cache_to_ram[c_addr_w+1:4], 2'b00};
  end else begin : g_single_line
    assign w_base = '0;
  end

  // The offset bits and the high address bits do not select anything.
  assign w_unused_addr = ^addr_cache_to_ram;

  // The base is line aligned, so adding the beat never carries into the
  // line index. Wrap past the top word comes from the index width.
  assign w_word_idx  = r_base + c_addr_w'(r_beat);
  assign w_mem_rdata = r_mem[w_word_idx];
  assign w_mem_wdata = r_wdata[{r_beat, 5'd0} +: 32];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
      r_beat    <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_beat    <= w_beat_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_beat_next    = r_beat;
    w_accept       = 1'b0;
    w_mem_we       = 1'b0;
    w_rd_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_cache_to_ram) begin
          w_accept       = 1'b1;
          w_lat_cnt_next = 4'd0;
          w_beat_next    = 2'd0;
          w_state_next   = (LATENCY > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == c_lat_last) begin
          w_lat_cnt_next = 4'd0;
          w_state_next   = S_XFER;
        end else begin
          w_lat_cnt_next = r_lat_cnt + 4'd1;
        end
      end
      S_XFER: begin
        w_mem_we    = r_write;
        w_rd_beat   = ~r_write;
        w_beat_next = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        // Requests are not accepted here, even when enable is still high.
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and read-line assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= write_cache_to_ram;
        r_base  <= w_base;
        r_wdata <= data_cache_to_ram;
      end
      // Only reads touch the output line. A write-back leaves the last
      // refill visible.
      if (w_rd_beat) begin
        r_rdata[{r_beat, 5'd0} +: 32] <= w_mem_rdata;
      end
    end
  end

  // The backing store has no reset. Contents survive reset, including words
  // written before an aborted transaction.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_word_idx] <= w_mem_wdata;
    end
  end

  assign response_ram_to_cache = (r_state == S_RESP);
  assign ram_busy              = (r_state != S_IDLE);
  assign data_ram_to_cache     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_line_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ram_line_responder
//  Purpose  : Self-checking bench for ram_line_responder at the default
//             parameters (MEM_WORDS=1024, LATENCY=2). It applies a table of
//             line transactions and then hand-written corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         wr  = 1'b0;
  logic [31:0]  addr  = '0;
  logic [127:0] wdata = '0;
  logic         resp;
  logic [127:0] rdata;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] W0 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] W1 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] W2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] W3 = 128'h33330003_22220002_11110001_00000000;
  localparam logic [127:0] G  = 128'hBADBADBA_BADBADBA_BADBADBA_BADBADBA;
  localparam logic [127:0] P  = 128'h50000003_50000002_50000001_50000000;
  localparam logic [127:0] Q  = 128'h90000003_90000002_90000001_90000000;

  always #5 clk = ~clk;

  ram_line_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_cache_to_ram   (en),
    .write_cache_to_ram    (wr),
    .addr_cache_to_ram     (addr),
    .data_cache_to_ram     (wdata),
    .response_ram_to_cache (resp),
    .data_ram_to_cache     (rdata),
    .ram_busy              (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [127:0] d;
    logic [127:0] exp;   // data_ram_to_cache expected in the response cycle
  } vec_t;

  vec_t vecs[8];

  // One complete transaction. The accept edge is the first rising edge after
  // the request is driven. The response must appear 6 edges later and last
  // one cycle.
  task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [127:0] d, input logic [127:0] exp);
    logic [127:0] d0;
    logic         busy_ok;
    logic         hold_ok;
    int           lat;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; wdata = d;
    d0 = rdata; busy_ok = 1'b1; hold_ok = 1'b1; lat = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if (resp) break;
      if (!busy) busy_ok = 1'b0;
      if (w && (rdata !== d0)) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd6);
    chk({tag, "_busy_until_resp"}, {127'd0, busy_ok & busy}, 128'd1);
    if (w) chk({tag, "_rdata_held"}, {127'd0, hold_ok}, 128'd1);
    chk({tag, "_rdata"}, rdata, exp);
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_resp_one_cycle"}, {126'd0, resp, busy}, 128'd0);
  endtask

  initial begin
    int           n_resp;
    int           c1;
    int           c2;
    logic         idle_busy;
    logic [127:0] rd2;

    vecs[0] = '{1'b1, 32'h0000_0040, W0, 128'd0};
    vecs[1] = '{1'b0, 32'h0000_0048, '0, W0};
    vecs[2] = '{1'b1, 32'h0000_1000, W1, W0};
    vecs[3] = '{1'b0, 32'h0000_0000, '0, W1};
    vecs[4] = '{1'b1, 32'hFFFF_FFF0, W2, W1};
    vecs[5] = '{1'b0, 32'h0000_0FF0, '0, W2};
    vecs[6] = '{1'b0, 32'h0000_004C, '0, W0};
    vecs[7] = '{1'b0, 32'h0000_1040, '0, W0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rdata[125:0], resp, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
    end

    // Write-back with enable held through the response, then a refill.
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0080; wdata = W3;
    @(posedge clk); #1;
    n_resp = 0; c1 = -1; c2 = -1; idle_busy = 1'b1; rd2 = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (resp) begin
        n_resp++;
        if (c1 < 0) begin
          c1 = cyc; wdata = G;
        end else if (c2 < 0) begin
          c2 = cyc; rd2 = rdata; en = 1'b0;
        end
      end else if (c1 >= 0 && c2 < 0 && cyc == c1 + 1) begin
        idle_busy = busy; wr = 1'b0;
      end
    end
    chk("b2b_first_resp", 128'(c1), 128'd6);
    chk("b2b_idle_gap", {127'd0, idle_busy}, 128'd0);
    chk("b2b_second_resp", 128'(c2), 128'd14);
    chk("b2b_resp_count", 128'(n_resp), 128'd2);
    chk("b2b_refill_data", rd2, W3);

    // Drop enable and change the request mid-read.
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h0000_0040; wdata = '0;
    @(posedge clk); #1;
    n_resp = 0; c1 = -1; rd2 = '0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin
        en = 1'b0; addr = 32'h0000_1000; wr = 1'b1; wdata = G;
      end
      if (resp) begin
        n_resp++;
        if (c1 < 0) begin
          c1 = cyc; rd2 = rdata;
        end
      end
    end
    chk("midchg_resp_count", 128'(n_resp), 128'd1);
    chk("midchg_latency", 128'(c1), 128'd6);
    chk("midchg_rdata", rd2, W0);

    // Reset at beat 2 of a write: words 0-1 land, words 2-3 keep old data.
    run_txn("pre_abort_wr", 1'b1, 32'h0000_0200, P, W0);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0200; wdata = Q;
    @(posedge clk);        // accept edge
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0; en = 1'b0;
    #1;
    chk("abort_outputs", {rdata[125:0], resp, busy}, 128'd0);
    n_resp = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp) n_resp++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp) n_resp++;
    end
    chk("abort_no_resp", 128'(n_resp), 128'd0);
    run_txn("post_abort_rd", 1'b0, 32'h0000_0200, '0, {P[127:64], Q[63:0]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_line_responder.md
RAM_LINE_RESPONDER -- requirements
Module: ram_line_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning backing store depth in 32-bit words (power of 2, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, meaning access wait cycles before the transfer (0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port enable_cache_to_ram  input  1  meaning request valid from the cache controller, held high until the response.
REQ-006 SHALL have port write_cache_to_ram  input  1  meaning 1 = line write-back, 0 = line refill read.
REQ-007 SHALL have port addr_cache_to_ram  input  32  meaning byte address; bits [3:0] ignored (line aligned).
REQ-008 SHALL have port data_cache_to_ram  input  128  meaning write line; word k in bits [32k+31:32k].
REQ-009 SHALL have port response_ram_to_cache  output  1  meaning one-cycle completion pulse.
REQ-010 SHALL have port data_ram_to_cache  output  128  meaning read line, same word packing as REQ-008.
REQ-011 SHALL have port ram_busy  output  1  meaning high in every state other than IDLE.

Function
REQ-012 SHALL implement the states IDLE, WAIT, XFER and RESP.
REQ-013 IDLE SHALL, with enable_cache_to_ram=1, latch addr, write flag and write data on the edge, then go to WAIT (LATENCY>0) or XFER (LATENCY=0).
REQ-014 WAIT SHALL count LATENCY cycles, then go to XFER.
REQ-015 XFER SHALL take exactly 4 cycles; beat k (0..3) SHALL access word index ({line index,2'b00}+k) mod MEM_WORDS.
REQ-016 A write XFER SHALL store latched data word k into memory at beat k.
REQ-017 A read XFER SHALL place memory word k into data_ram_to_cache word k at beat k.
REQ-018 XFER SHALL go to RESP after beat 3; RESP SHALL assert response_ram_to_cache for exactly one cycle, then return to IDLE.
REQ-019 Response SHALL be high in the cycle beginning LATENCY+4 edges after the accept edge (LATENCY=2: 6 edges).
REQ-020 The line index SHALL be addr[31:4] truncated modulo MEM_WORDS/4, so out-of-range addresses wrap with no error.
REQ-021 A request SHALL NOT be accepted in WAIT, XFER or RESP; enable still high during the RESP cycle SHALL NOT start a new request.
REQ-022 IDLE SHALL accept a new request on the first edge after RESP if enable is high (back-to-back write-back then refill).
REQ-023 Once accepted, a request SHALL complete; mid-transaction changes or deassertion of enable, write, addr or data SHALL be ignored.
REQ-024 data_ram_to_cache SHALL hold its last completed read line and SHALL NOT change during a write transaction.
REQ-025 During a read, data_ram_to_cache words 0..3 SHALL update as they are read; the line SHALL be whole and stable in the RESP cycle.
REQ-026 A read of a line written by the immediately preceding transaction SHALL return the new data (no hazard).

Reset
REQ-027 rst=0 SHALL, asynchronously, force IDLE and set response_ram_to_cache=0, ram_busy=0, data_ram_to_cache=0 and the latency counter and beat counter to 0.
REQ-028 Reset mid-transaction SHALL abort it with no response; words already written SHALL persist.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 After rst deassertion, the first request SHALL be accepted on the first rising edge at which enable=1.

Verification
REQ-031 Write 0x0000_0040, data {0x44,0x33,0x22,0x11}, LATENCY=2 -> response high exactly 6 edges after accept, 1 cycle; ram_busy high until then.
REQ-032 Then read 0x0000_0048 -> data_ram_to_cache=0x00000044_00000033_00000022_00000011 in the response cycle.
REQ-033 Write-back with enable held through response, then write=0 next cycle -> refill accepted on the edge after RESP; no duplicate write; two responses total.
REQ-034 MEM_WORDS=1024: write 0x0000_1000, read 0x0000_0000 -> same line (wrap).
REQ-035 Drop enable and change addr mid-read -> original line returned, one response.
REQ-036 Assert rst at beat 2 of a write -> no response, all outputs 0; words 0-1 updated, words 2-3 unchanged.
